// File: rtl/bt_pkg.sv
// Shared balanced-ternary definitions: trit codes, 7-segment glyphs and
// the code-to-value helper used by the result converter.
package bt_pkg;

    localparam logic [1:0] BT_NEG  = 2'b01;
    localparam logic [1:0] BT_ZERO = 2'b11;
    localparam logic [1:0] BT_POS  = 2'b10;
    localparam logic [1:0] BT_ILL  = 2'b00;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_NEG  = 7'b1000000;
    localparam logic [6:0] SEG_ZERO = 7'b0111111;
    localparam logic [6:0] SEG_POS  = 7'b0000110;
    localparam logic [6:0] SEG_ERR  = 7'b1111001;

    function automatic logic signed [1:0] bt_trit_val(input logic [1:0] code);
        case (code)
            BT_NEG:  return -2'sd1;
            BT_POS:  return 2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/bt_trit_to_seg.sv
// Combinational trit code to 7-segment glyph; illegal codes show "E".
module bt_trit_to_seg
    import bt_pkg::*;
(
    input  logic [1:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_ERR;
        case (i_code)
            BT_NEG:  o_seg = SEG_NEG;
            BT_ZERO: o_seg = SEG_ZERO;
            BT_POS:  o_seg = SEG_POS;
            default: o_seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/bt_result_scan_display.sv
// Captures the calculator result word, converts it MST-first to signed binary,
// and scans the captured trits onto one 7-segment digit.
module bt_result_scan_display
    import bt_pkg::*;
#(
    parameter int N_TRITS  = 4,
    parameter int VAL_W    = 7,
    parameter int PRESCALE = 1024,
    localparam int CNT_W   = (N_TRITS > 1) ? $clog2(N_TRITS) : 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*N_TRITS-1:0]    res_in,
    input  logic                    sample,
    output logic                    busy,
    output logic                    val_valid,
    output logic signed [VAL_W-1:0] val,
    output logic                    err,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [CNT_W-1:0]        digit_idx
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]              r_state;
    logic [2*N_TRITS-1:0]    r_cap_q;
    logic signed [VAL_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [VAL_W-1:0] r_val;
    logic                    r_val_valid;
    logic                    r_err;
    logic [PS_W-1:0]         r_prescale;
    logic [CNT_W-1:0]        r_digit_idx;
    logic [6:0]              r_seg;
    logic                    r_dp;

    logic [1:0]              w_trits [N_TRITS];
    logic                    w_res_ill;
    logic signed [1:0]       w_trit_val;
    logic signed [VAL_W-1:0] w_acc_next;
    logic [6:0]              w_scan_seg;

    // Trit k sits high-bit-first at res_in[2N-1-2k -: 2]; trit 0 is the LST
    always_comb begin
        w_res_ill = 1'b0;
        for (int k = 0; k < N_TRITS; k++) begin
            w_trits[k] = r_cap_q[2*N_TRITS-1-2*k -: 2];
            if (res_in[2*N_TRITS-1-2*k -: 2] == BT_ILL) begin
                w_res_ill = 1'b1;
            end
        end
    end

    // Horner step: illegal trits contribute 0 so the value stays defined
    assign w_trit_val = bt_trit_val(w_trits[r_cnt]);
    assign w_acc_next = r_acc + r_acc + r_acc
                      + {{(VAL_W-2){w_trit_val[1]}}, w_trit_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cap_q     <= {N_TRITS{BT_ZERO}};
            r_acc       <= '0;
            r_cnt       <= '0;
            r_val       <= '0;
            r_val_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_val_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample) begin
                        r_cap_q <= res_in;
                        r_err   <= w_res_ill;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(N_TRITS-1);
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_val       <= w_acc_next;
                        r_val_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    bt_trit_to_seg u_trit_to_seg (
        .i_code (w_trits[r_digit_idx]),
        .o_seg  (w_scan_seg)
    );

    // Free-running scan; seg/dp lag digit_idx by one register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale  <= '0;
            r_digit_idx <= '0;
            r_seg       <= SEG_ZERO;
            r_dp        <= 1'b1;
        end else begin
            if (r_prescale == PS_W'(PRESCALE-1)) begin
                r_prescale  <= '0;
                r_digit_idx <= (r_digit_idx == CNT_W'(N_TRITS-1)) ? '0
                                                                 : r_digit_idx + CNT_W'(1);
            end else begin
                r_prescale <= r_prescale + PS_W'(1);
            end
            r_seg <= w_scan_seg;
            r_dp  <= (r_digit_idx == '0);
        end
    end

    assign busy      = (r_state == ST_CONV);
    assign val_valid = r_val_valid;
    assign val       = r_val;
    assign err       = r_err;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_bt_result_scan_display.sv
// Directed bench for bt_result_scan_display (N_TRITS=4, VAL_W=7, PRESCALE=4).
module tb_bt_result_scan_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] res_in;
    logic       sample;
    logic       busy;
    logic       val_valid;
    logic [6:0] val;
    logic       err;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_idx;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [6:0] exp_q[$];

    localparam logic [6:0] P_NEG  = 7'b1000000;
    localparam logic [6:0] P_ZERO = 7'b0111111;
    localparam logic [6:0] P_POS  = 7'b0000110;
    localparam logic [6:0] P_ERR  = 7'b1111001;

    bt_result_scan_display #(
        .N_TRITS  (4),
        .VAL_W    (7),
        .PRESCALE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_in    (res_in),
        .sample    (sample),
        .busy      (busy),
        .val_valid (val_valid),
        .val       (val),
        .err       (err),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_vv"},    32'(val_valid), 32'd0);
        check({tag, "_val"},   32'(val),       32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
        check({tag, "_seg"},   32'(seg),       32'(P_ZERO));
        check({tag, "_dp"},    32'(dp),        32'd1);
        check({tag, "_digit"}, 32'(digit_idx), 32'd0);
    endtask

    // Called at a negedge with the FSM idle; returns one cycle after the val_valid pulse
    task automatic do_conv(input string tag, input logic [7:0] res,
                           input logic [6:0] ev, input logic ee);
        int bc;
        int vv;
        res_in = res;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        bc = 0;
        vv = 0;
        for (int i = 0; i < 4; i++) begin
            bc += int'(busy);
            vv += int'(val_valid);
            res_in = ~res_in;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(bc), 32'd4);
        check({tag, "_vv_early"},    32'(vv), 32'd0);
        check({tag, "_vv"},          32'(val_valid), 32'd1);
        check({tag, "_busy_fall"},   32'(busy), 32'd0);
        check({tag, "_val"},         32'(val), 32'(ev));
        check({tag, "_err"},         32'(err), 32'(ee));
        @(negedge clk);
        check({tag, "_vv_pulse"},    32'(val_valid), 32'd0);
        check({tag, "_val_hold"},    32'(val), 32'(ev));
    endtask

    // Leaves the bench at the first negedge of a digit_idx==0 window
    task automatic sync_digit0(input string tag);
        int k;
        k = 0;
        while (digit_idx == 2'd0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        while (digit_idx != 2'd0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_sync"}, 32'(digit_idx == 2'd0 && k < 80), 32'd1);
    endtask

    initial begin
        logic [7:0] burst [12];
        logic [6:0] scan_seg [4];
        int last_c;
        int pulses;
        int vv_cnt;
        int busy_cnt;

        burst = '{8'hEB, 8'h55, 8'hAA, 8'h37, 8'h00, 8'h7B,
                  8'hFF, 8'h11, 8'hB7, 8'h55, 8'hAA, 8'h01};
        scan_seg = '{P_POS, P_ZERO, P_NEG, P_ZERO};

        rst_n  = 1'b0;
        res_in = 8'h00;
        sample = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        do_conv("b7", 8'hB7, 7'h78, 1'b0);
        do_conv("eb", 8'hEB, 7'd12, 1'b0);
        do_conv("7b", 8'h7B, 7'd8,  1'b0);
        do_conv("aa", 8'hAA, 7'd40, 1'b0);
        do_conv("55", 8'h55, 7'h58, 1'b0);

        do_conv("37", 8'h37, 7'h77, 1'b1);
        sync_digit0("ill");
        @(negedge clk);
        check("ill_digit", 32'(digit_idx), 32'd0);
        check("ill_seg",   32'(seg),       32'(P_ERR));
        check("ill_dp",    32'(dp),        32'd1);
        repeat (4) @(negedge clk);
        check("ill_digit1", 32'(digit_idx), 32'd1);
        check("ill_dp1",    32'(dp),        32'd0);

        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_conv("scan_cap", 8'hB7, 7'h78, 1'b0);
        sync_digit0("scan");
        @(negedge clk);
        for (int d = 0; d < 5; d++) begin
            check($sformatf("scan%0d_digit", d), 32'(digit_idx), 32'(d % 4));
            check($sformatf("scan%0d_seg", d),   32'(seg),       32'(scan_seg[d % 4]));
            check($sformatf("scan%0d_dp", d),    32'(dp),        32'(d % 4 == 0));
            repeat (4) @(negedge clk);
        end

        exp_q.push_back(7'd12);
        exp_q.push_back(7'd8);
        exp_q.push_back(7'd40);
        last_c = -1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (val_valid) begin
                pulses++;
                if (last_c >= 0) check($sformatf("burst_gap%0d", pulses), 32'(c - last_c), 32'd5);
                last_c = c;
                if (exp_q.size() > 0) check($sformatf("burst_val%0d", pulses), 32'(val), 32'(exp_q.pop_front()));
            end
            res_in = (c < 12) ? burst[c] : 8'h00;
            sample = (c < 12);
            @(negedge clk);
        end
        sample = 1'b0;
        check("burst_pulses", 32'(pulses), 32'd3);
        check("burst_q_empty", 32'(exp_q.size()), 32'd0);
        check("burst_err", 32'(err), 32'd0);

        res_in = 8'hAA;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_val",  32'(val),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vv_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vv_cnt += int'(val_valid);
            busy_cnt += int'(busy);
        end
        check("abort_no_vv",   32'(vv_cnt),   32'd0);
        check("abort_no_busy", 32'(busy_cnt), 32'd0);
        check("abort_val_rel", 32'(val),      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
